// File: rtl/comp_pkg.sv
// Shared encodings and helpers for the comparator qualifier stage.
package comp_pkg;

  localparam int unsigned REL_W        = 2;
  localparam int unsigned RUN_W        = 4;
  localparam int unsigned DEBOUNCE_MAX = (1 << RUN_W) - 1;

  typedef enum logic [REL_W-1:0] {
    REL_UNKNOWN = 2'b00,
    REL_AGT     = 2'b01,
    REL_EQ      = 2'b10,
    REL_BGT     = 2'b11
  } rel_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_A    = 2'b01,
    DIR_B    = 2'b10
  } dir_e;

  // One-hot flags map to a relation; anything else decodes to REL_UNKNOWN (illegal).
  function automatic rel_e decode_rel(input logic ag, input logic eq, input logic bg);
    rel_e r;
    case ({ag, eq, bg})
      3'b100:  r = REL_AGT;
      3'b010:  r = REL_EQ;
      3'b001:  r = REL_BGT;
      default: r = REL_UNKNOWN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comp_qualifier_if.sv
// Comparator flags in, qualified relation and event flags out.
interface comp_qualifier_if #(
  parameter int unsigned CNT_W = 8
);
  logic             EN;
  logic             ag;
  logic             eq;
  logic             bg;
  logic [1:0]       state;
  logic             valid;
  logic             rise_a;
  logic             rise_b;
  logic             evt;
  logic [CNT_W-1:0] cross_cnt;
  logic             err;

  modport master (
    output EN, ag, eq, bg,
    input  state, valid, rise_a, rise_b, evt, cross_cnt, err
  );

  modport slave (
    input  EN, ag, eq, bg,
    output state, valid, rise_a, rise_b, evt, cross_cnt, err
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones; clr and inc together yield 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] base_c;

  always_comb begin
    base_c = clr ? '0 : q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (base_c != '1)) begin
      q <= base_c + W'(1);
    end else begin
      q <= base_c;
    end
  end

endmodule

// File: rtl/comp_qualifier.sv
// Debounces comparator flags into a qualified relation with entry pulses,
// crossing count and a sticky illegal-input flag.
module comp_qualifier
  import comp_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic           CLK,
  input  logic           RST,
  comp_qualifier_if.slave bus
);

  localparam logic [RUN_W-1:0] DEB = RUN_W'(DEBOUNCE);

  rel_e             state_q, state_d;
  rel_e             cand_q, cand_d;
  dir_e             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             evt_q, evt_d;
  logic             rise_a_q, rise_a_d;
  logic             rise_b_q, rise_b_d;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_nxt_c;
  logic [CNT_W-1:0] cross_q;
  rel_e             rel_c;
  logic             legal_c;
  logic             same_c;
  logic             qualify_c;
  logic             run_clr_c;
  logic             run_inc_c;
  logic             cross_inc_c;
  dir_e             new_dir_c;

  // Decode and the run length the counter will hold after this edge.
  always_comb begin
    rel_c     = decode_rel(bus.ag, bus.eq, bus.bg);
    legal_c   = (rel_c != REL_UNKNOWN);
    same_c    = (rel_c == cand_q);
    run_nxt_c = RUN_W'(1);
    if (same_c) begin
      run_nxt_c = (run_q >= DEB) ? DEB : (run_q + RUN_W'(1));
    end
    run_clr_c = bus.EN && (!legal_c || !same_c);
    run_inc_c = bus.EN && legal_c && (!same_c || (run_q < DEB));
    qualify_c = bus.EN && legal_c && (run_nxt_c == DEB) && (rel_c != state_q);
  end

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (run_clr_c),
    .inc   (run_inc_c),
    .q     (run_q)
  );

  sat_counter #(.W(CNT_W)) u_cross_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (1'b0),
    .inc   (cross_inc_c),
    .q     (cross_q)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= REL_UNKNOWN;
      cand_q   <= REL_UNKNOWN;
      dir_q    <= DIR_NONE;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      evt_q    <= 1'b0;
      rise_a_q <= 1'b0;
      rise_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      dir_q    <= dir_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      evt_q    <= evt_d;
      rise_a_q <= rise_a_d;
      rise_b_q <= rise_b_d;
    end
  end

  // Next state: EQ qualifies but never moves the direction used for crossings.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    dir_d       = dir_q;
    err_d       = err_q;
    evt_d       = 1'b0;
    rise_a_d    = 1'b0;
    rise_b_d    = 1'b0;
    cross_inc_c = 1'b0;
    new_dir_c   = DIR_NONE;
    if (bus.EN) begin
      if (!legal_c) begin
        err_d  = 1'b1;
        cand_d = REL_UNKNOWN;
      end else begin
        cand_d = rel_c;
        if (qualify_c) begin
          state_d  = rel_c;
          evt_d    = 1'b1;
          rise_a_d = (rel_c == REL_AGT);
          rise_b_d = (rel_c == REL_BGT);
          if (rel_c == REL_AGT) begin
            new_dir_c = DIR_A;
          end else if (rel_c == REL_BGT) begin
            new_dir_c = DIR_B;
          end
          if (new_dir_c != DIR_NONE) begin
            dir_d       = new_dir_c;
            cross_inc_c = (dir_q != DIR_NONE) && (dir_q != new_dir_c);
          end
        end
      end
    end
    valid_d = (state_d != REL_UNKNOWN);
  end

  assign bus.state     = state_q;
  assign bus.valid     = valid_q;
  assign bus.rise_a    = rise_a_q;
  assign bus.rise_b    = rise_b_q;
  assign bus.evt       = evt_q;
  assign bus.cross_cnt = cross_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_comp_qualifier.sv
// Directed bench for comp_qualifier: main instance CNT_W=8, second instance CNT_W=2.
module tb_comp_qualifier;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  comp_qualifier_if #(.CNT_W(8)) b1 ();
  comp_qualifier_if #(.CNT_W(2)) b2 ();

  comp_qualifier #(.DEBOUNCE(3), .CNT_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (b1.slave)
  );

  comp_qualifier #(.DEBOUNCE(3), .CNT_W(2)) dut_sat (
    .CLK (CLK),
    .RST (RST),
    .bus (b2.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Same stimulus to both instances, then sample 1 time unit after the edge.
  task automatic step(input logic a, input logic e, input logic b, input logic en);
    b1.ag = a; b1.eq = e; b1.bg = b; b1.EN = en;
    b2.ag = a; b2.eq = e; b2.bg = b; b2.EN = en;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    RST = 1'b1;
  endtask

  task automatic pulses(input string tag, input logic ra, input logic rb, input logic ev);
    check({tag, ".rise_a"}, 32'(b1.rise_a), 32'(ra));
    check({tag, ".rise_b"}, 32'(b1.rise_b), 32'(rb));
    check({tag, ".evt"},    32'(b1.evt),    32'(ev));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST    = 1'b0;

    // Reset held two cycles with ag/EN asserted.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("rst.state", 32'(b1.state), 32'd0);
    check("rst.valid", 32'(b1.valid), 32'd0);
    check("rst.err",   32'(b1.err),   32'd0);
    check("rst.cross", 32'(b1.cross_cnt), 32'd0);
    pulses("rst", 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("q1.state", 32'(b1.state), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("q2.state", 32'(b1.state), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("q3.state", 32'(b1.state), 32'd1);
    check("q3.valid", 32'(b1.valid), 32'd1);
    pulses("q3", 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("q4.state", 32'(b1.state), 32'd1);
    pulses("q4", 1'b0, 1'b0, 1'b0);

    // Chatter: ag,ag,bg,ag,ag,ag qualifies only on the 6th edge.
    do_reset();
    begin
      logic [5:0] seq_b;
      seq_b = 6'b000100;
      for (int i = 0; i < 6; i++) begin
        step(~seq_b[i], 1'b0, seq_b[i], 1'b1);
        check($sformatf("chat%0d.state", i), 32'(b1.state), (i == 5) ? 32'd1 : 32'd0);
        check($sformatf("chat%0d.rise_b", i), 32'(b1.rise_b), 32'd0);
      end
    end

    // Crossings from A_GT: EQ, B_GT, A_GT, then A->EQ->A.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("x_eq.state", 32'(b1.state), 32'd2);
    check("x_eq.cross", 32'(b1.cross_cnt), 32'd0);
    pulses("x_eq", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("x_b.state", 32'(b1.state), 32'd3);
    check("x_b.cross", 32'(b1.cross_cnt), 32'd1);
    pulses("x_b", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("x_a.state", 32'(b1.state), 32'd1);
    check("x_a.cross", 32'(b1.cross_cnt), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("x_aea.state", 32'(b1.state), 32'd1);
    check("x_aea.cross", 32'(b1.cross_cnt), 32'd2);

    // Illegal input mid-run restarts the run and sets sticky err.
    do_reset();
    check("ill.err_rst", 32'(b1.err), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("ill.err", 32'(b1.err), 32'd1);
    check("ill.state", 32'(b1.state), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("ill2.state", 32'(b1.state), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("ill3.state", 32'(b1.state), 32'd1);
    check("ill3.err", 32'(b1.err), 32'd1);

    // EN low holds everything even with a different relation on the inputs.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("en%0d.state", i), 32'(b1.state), 32'd0);
      pulses($sformatf("en%0d", i), 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("en_q.state", 32'(b1.state), 32'd1);
    pulses("en_q", 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("en_off.state", 32'(b1.state), 32'd1);
    pulses("en_off", 1'b0, 1'b0, 1'b0);

    // Reset mid-run discards the partial run.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("rmr2.state", 32'(b1.state), 32'd0);
    check("rmr2.valid", 32'(b1.valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("rmr3.state", 32'(b1.state), 32'd1);

    // Alternate A/B qualifications: six reversals, 2-bit counter saturates at 3.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      logic a;
      a = (i % 2 == 0);
      for (int k = 0; k < 3; k++) step(a, 1'b0, ~a, 1'b1);
      check($sformatf("sat%0d.state", i), 32'(b2.state), a ? 32'd1 : 32'd3);
      check($sformatf("sat%0d.cnt8", i), 32'(b1.cross_cnt), 32'(i));
      check($sformatf("sat%0d.cnt2", i), 32'(b2.cross_cnt), (i > 3) ? 32'd3 : 32'(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_qualifier.md
Name: comp_qualifier

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator `comp`. It consumes `comp`'s one-hot ag/eq/bg flags.
- Debounces the comparator relation over DEBOUNCE consecutive enabled cycles and publishes a qualified relation state.
- Emits one-cycle entry pulses, counts A-over/B-over crossings and flags illegal (non-one-hot) comparator output.
- Used in the IIR datapath for threshold/limit detection on sample magnitudes.

Parameters:
- DEBOUNCE, 3, consecutive enabled cycles of identical relation required to qualify; legal range 1..15.
- CNT_W, 8, width of crossing counter.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous reset, active-low.
- EN  input  1  sample enable; when low all state holds.
- ag  input  1  comparator flag A>B.
- eq  input  1  comparator flag A==B.
- bg  input  1  comparator flag B>A.
- state  output  2  qualified relation: 2'b00 UNKNOWN, 2'b01 A_GT, 2'b10 EQ, 2'b11 B_GT.
- valid  output  1  high once state has left UNKNOWN.
- rise_a  output  1  one-cycle pulse on entry to A_GT.
- rise_b  output  1  one-cycle pulse on entry to B_GT.
- evt  output  1  one-cycle pulse on any state change.
- cross_cnt  output  CNT_W  saturating count of direction reversals.
- err  output  1  sticky: non-one-hot input seen.

Behaviour:
- Reset (RST=0 at rising CLK): state=UNKNOWN, valid=0, rise_a=rise_b=evt=0, cross_cnt=0, err=0.
  - Internal state also resets: cand=UNKNOWN, run_cnt=0, last_dir=NONE.
  - Reset overrides EN. Reset mid-run discards any partial run.
- Decode (combinational): exactly one of ag/eq/bg high gives rel = A_GT/EQ/B_GT. Any other combination (none, or two or more high) is illegal.
- Per enabled edge (EN=1), legal rel:
  - If rel==cand: run_cnt <= min(run_cnt+1, DEBOUNCE).
  - Otherwise: cand <= rel, run_cnt <= 1.
  - Qualification occurs on the edge where the new run_cnt value equals DEBOUNCE and rel != state. On that edge: state <= rel and evt <= 1. Also rise_a <= (rel==A_GT) and rise_b <= (rel==B_GT).
  - Latency: state updates on the same edge that samples the DEBOUNCE-th consecutive matching value. With DEBOUNCE=1, state follows input one edge later.
- Per enabled edge, illegal input: err <= 1 (sticky until reset), cand <= UNKNOWN, run_cnt <= 0; state held.
- EN=0: cand, run_cnt, state, cross_cnt and last_dir hold. Pulses forced to 0 on that edge.
- Pulses: rise_a, rise_b and evt are high for exactly one cycle. They are 0 on every edge without qualification.
- Crossing logic: last_dir in {NONE, A, B} updates only when state becomes A_GT or B_GT. EQ does not change last_dir.
  - If new dir != last_dir and last_dir != NONE: cross_cnt <= cross_cnt+1, saturating at all-ones (no wrap).
  - A_GT -> EQ -> B_GT counts as one crossing. A_GT -> EQ -> A_GT counts none.
- Re-qualifying the current state (rel==state) produces no pulse and no count.
- valid = (state != UNKNOWN). After reset, UNKNOWN is never re-entered.

Decomposition:
- Shared package comp_pkg:
  - relation encodings REL_UNKNOWN/REL_AGT/REL_EQ/REL_BGT;
  - last_dir encodings DIR_NONE/DIR_A/DIR_B;
  - the rule DEBOUNCE<=15 (run_cnt width 4).
- One sub-module: sat_counter (parameter W; sync active-low reset; inc and clr inputs; saturates at all-ones). Instantiated for run_cnt (clr on candidate change) and for cross_cnt.
- FSM and decode live in comp_qualifier.

Test Plan (DEBOUNCE=3, CNT_W=8 unless stated):
- Reset: RST=0 for 2 cycles with ag=1, EN=1 -> state=00, valid=0, err=0, cross_cnt=0. Release RST, hold ag=1 3 cycles -> state=01 after 3rd edge, valid=1, rise_a=evt=1 for exactly that one cycle.
- Chatter: ag,ag,bg,ag,ag,ag -> no state change until the 6th edge, then state=01. rise_b never asserted.
- Crossings: from A_GT, eq x3 -> state=10, cross_cnt=0; then bg x3 -> state=11, rise_b pulse, cross_cnt=1; then ag x3 -> cross_cnt=2. With CNT_W=2, six reversals -> cross_cnt stays 3.
- Illegal input: mid-run ag=bg=1 for one cycle -> err=1 and stays 1. Run restarts; 3 further clean ag edges are required to qualify.
- EN gating: ag, ag, EN=0 for 4 cycles, ag -> qualifies on the 3rd enabled edge; no pulses while EN=0.
- Reset mid-run: 2 ag edges, RST=0 one cycle, 2 ag edges -> state stays UNKNOWN; the 3rd post-reset ag edge qualifies.
